// File: rtl/code_monitor.sv
// Buffers upstream 2-bit codes in a FIFO, drains one per cycle, counts each code value
// with saturation and pulses seq_hit when the sequence 01 -> 10 -> 11 completes.
module code_monitor #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [1:0]               in_code,
  output logic                     in_ready,
  input  logic                     hold,
  input  logic                     clr,
  input  logic [1:0]               cnt_sel,
  output logic [CNT_W-1:0]         cnt_out,
  output logic                     seq_hit,
  output logic                     sat,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S0, S1, S2} state_t;

  logic [1:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  state_t           state_q, state_d;
  logic             seq_hit_q, hit_d;
  logic             push, pop;
  logic [1:0]       pop_code;

  // in_ready depends on registered occupancy only, so a pop never frees a slot in its own cycle
  assign in_ready = (level_q != FULL_LVL);
  assign push     = in_valid && in_ready;
  assign pop      = (level_q != '0) && !hold;
  assign pop_code = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign seq_hit  = seq_hit_q;
  assign cnt_out  = cnt_q[cnt_sel];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_code;
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // A pop that coincides with clr is discarded: not counted and not fed to the FSM
  always_comb begin
    for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];
    if (clr) begin
      for (int i = 0; i < 4; i++) cnt_d[i] = '0;
    end else if (pop && (cnt_q[pop_code] != CNT_MAX)) begin
      cnt_d[pop_code] = cnt_q[pop_code] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cnt_q[i] == CNT_MAX) sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S0;
      seq_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_hit_q <= hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S0;
    end else if (pop) begin
      case (state_q)
        S0:      state_d = (pop_code == 2'b01) ? S1 : S0;
        S1:      state_d = (pop_code == 2'b10) ? S2 :
                           (pop_code == 2'b01) ? S1 : S0;
        S2:      state_d = (pop_code == 2'b01) ? S1 : S0;
        default: state_d = S0;
      endcase
    end
  end

  always_comb begin
    hit_d = 1'b0;
    if (!clr && pop && (state_q == S2) && (pop_code == 2'b11)) hit_d = 1'b1;
  end

endmodule

// File: tb/tb_code_monitor.sv
// Directed bench for code_monitor (DEPTH=4, CNT_W=3) with hand-computed expectations.
module tb_code_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_code = 2'b00;
  logic       in_ready;
  logic       hold = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] cnt_sel = 2'b00;
  logic [2:0] cnt_out;
  logic       seq_hit;
  logic       sat;
  logic [2:0] level;

  int passes = 0;
  int total  = 0;

  code_monitor #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .hold(hold), .clr(clr), .cnt_sel(cnt_sel),
    .cnt_out(cnt_out), .seq_hit(seq_hit), .sat(sat), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [1:0] sel, input int exp);
    cnt_sel = sel;
    #1;
    chk(tag, {29'd0, cnt_out}, exp);
  endtask

  logic [1:0] seq_codes [8];
  logic [1:0] full_codes [5];
  logic [1:0] wrap_codes [14];
  int         model [4];

  initial begin
    seq_codes  = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
    full_codes = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
    wrap_codes = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd3,
                   2'd2, 2'd2, 2'd1, 2'd0, 2'd3, 2'd1};

    #1 rst_n = 1'b0;
    #1;
    chk("init_level", level, 0);
    chk("init_ready", in_ready, 1);
    chk("init_hit", seq_hit, 0);
    chk("init_sat", sat, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Build counter[1]=5, then queue 3 codes under hold and reset mid-cycle
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_code = 2'b01;
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    chk_cnt("pre_rst_cnt1", 2'd1, 5);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_code = 2'(i + 2);
      cyc();
    end
    in_valid = 1'b0;
    chk("pre_rst_level", level, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_hit", seq_hit, 0);
    chk("rst_sat", sat, 0);
    for (int s = 0; s < 4; s++) chk_cnt("rst_cnt", 2'(s), 0);
    #1 rst_n = 1'b1;
    hold = 1'b0;

    // Sequence detection: hits on the cycles after popping codes 3 and 6
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      in_code  = (i < 8) ? seq_codes[i] : 2'b00;
      cyc();
      chk("seq_hit", seq_hit, (i == 3 || i == 6) ? 1 : 0);
      chk("seq_level", level, (i <= 7) ? 1 : 0);
    end
    in_valid = 1'b0;
    chk_cnt("seq_cnt0", 2'd0, 0);
    chk_cnt("seq_cnt1", 2'd1, 2);
    chk_cnt("seq_cnt2", 2'd2, 3);
    chk_cnt("seq_cnt3", 2'd3, 3);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk_cnt("clr_cnt3", 2'd3, 0);

    // Full FIFO under hold, then release
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_code = full_codes[i];
      cyc();
      chk("fill_level", level, i + 1);
      chk("fill_ready", in_ready, (i < 3) ? 1 : 0);
    end
    in_code = full_codes[4];
    cyc();
    chk("full_block1", level, 4);
    cyc();
    chk("full_block2", level, 4);
    hold = 1'b0;
    cyc();
    chk("rel_level1", level, 3);
    chk("rel_ready1", in_ready, 1);
    chk_cnt("rel_pop1_cnt1", 2'd1, 1);
    cyc();
    in_valid = 1'b0;
    chk("rel_level2", level, 3);
    chk_cnt("rel_pop2_cnt2", 2'd2, 1);
    cyc();
    chk("rel_level3", level, 2);
    chk_cnt("rel_pop3_cnt3", 2'd3, 1);
    cyc();
    chk("rel_level4", level, 1);
    chk_cnt("rel_pop4_cnt0", 2'd0, 1);
    cyc();
    chk("rel_level5", level, 0);
    chk_cnt("rel_pop5_cnt2", 2'd2, 2);
    clr = 1'b1;
    cyc();
    clr = 1'b0;

    // Saturation at 7 for a 3-bit counter
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 9); in_code = 2'b10;
      cyc();
      chk("sat_flag", sat, (i >= 7) ? 1 : 0);
      chk_cnt("sat_cnt2", 2'd2, (i < 7) ? i : 7);
    end
    in_valid = 1'b0;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk_cnt("sat_clr_cnt2", 2'd2, 0);
    chk("sat_clr_flag", sat, 0);

    // clr colliding with the pop of the completing 11
    in_valid = 1'b1; in_code = 2'b01;
    cyc();
    in_code = 2'b10;
    cyc();
    in_code = 2'b11;
    cyc();
    in_valid = 1'b0;
    chk("col_level_before", level, 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("col_level_after", level, 0);
    chk("col_hit1", seq_hit, 0);
    chk_cnt("col_cnt3", 2'd3, 0);
    cyc();
    chk("col_hit2", seq_hit, 0);
    in_valid = 1'b1; in_code = 2'b11;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("col_fsm_s0", seq_hit, 0);
    clr = 1'b1;
    cyc();
    clr = 1'b0;

    // Wrap-around with the FIFO held at level 2
    for (int s = 0; s < 4; s++) model[s] = 0;
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_code = wrap_codes[i];
      cyc();
    end
    chk("wrap_prefill", level, 2);
    hold = 1'b0;
    for (int k = 0; k < 14; k++) begin
      in_valid = (k < 12);
      in_code  = (k < 12) ? wrap_codes[k + 2] : 2'b00;
      cyc();
      model[wrap_codes[k]]++;
      chk("wrap_level", level, (k < 12) ? 2 : 13 - k);
      chk_cnt("wrap_order", wrap_codes[k], model[wrap_codes[k]]);
    end
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
